// File: rtl/termbuf_pkg.sv
// Shared constants and types for the character-cell text buffer.
// The geometry defaults are shared with termctl so its x wrap point matches COLS.
package termbuf_pkg;

  localparam int unsigned TERM_COLS  = 100;
  localparam int unsigned TERM_ROWS  = 30;
  localparam logic [7:0]  TERM_BLANK = 8'h00;
  localparam int unsigned TERM_ADDRW = 12;

  localparam int unsigned XW = 7;
  localparam int unsigned YW = 5;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StWrite,
    StAck
  } tb_state_e;

  // x and y are zero-extended before the compare.
  function automatic logic in_bounds(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                     input int unsigned cols, input int unsigned rows);
    return (32'(x) < cols) && (32'(y) < rows);
  endfunction

endpackage

// File: rtl/termbuf_ram.sv
// Simple dual-port cell RAM: one synchronous write port, one registered read-first read port.
module termbuf_ram #(
  parameter int unsigned DEPTH = 3000,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ADDRW = 12
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ADDRW-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [ADDRW-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Nonblocking update makes a same-edge read return the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/termbuf.sv
// Character-cell text buffer: responder end of the 4-phase cell-write handshake, post-reset
// clear sweep, and a registered read port for the VGA text renderer.
module termbuf
  import termbuf_pkg::*;
#(
  parameter int unsigned COLS  = TERM_COLS,
  parameter int unsigned ROWS  = TERM_ROWS,
  parameter logic [7:0]  BLANK = TERM_BLANK,
  parameter int unsigned ADDRW = TERM_ADDRW
) (
  input  logic          i_vgaclk,
  input  logic          i_rst,
  input  logic          i_writereq,
  input  logic [XW-1:0] i_xwrite,
  input  logic [YW-1:0] i_ywrite,
  input  logic [CW-1:0] i_charin,
  output logic          o_writeack,
  output logic          o_busy,
  output logic          o_dropped,
  input  logic [XW-1:0] i_rdx,
  input  logic [YW-1:0] i_rdy,
  output logic [CW-1:0] o_rdchar
);

  localparam int unsigned     DEPTH     = COLS * ROWS;
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  tb_state_e        r_state, w_state_nxt;
  logic [ADDRW-1:0] r_cnt, w_cnt_nxt;
  logic [XW-1:0]    r_x, w_x_nxt;
  logic [YW-1:0]    r_y, w_y_nxt;
  logic [CW-1:0]    r_char, w_char_nxt;
  logic             r_writeack, w_writeack_nxt;
  logic             r_dropped, w_dropped_nxt;
  logic             r_rd_ok;

  logic             w_we;
  logic [ADDRW-1:0] w_waddr;
  logic [CW-1:0]    w_wdata;
  logic             w_wr_ok;
  logic [ADDRW-1:0] w_cell_addr;
  logic             w_rd_ok;
  logic [ADDRW-1:0] w_raddr;
  logic [CW-1:0]    w_ram_q;

  assign w_wr_ok     = in_bounds(r_x, r_y, COLS, ROWS);
  assign w_cell_addr = ADDRW'(r_y) * ADDRW'(COLS) + ADDRW'(r_x);

  always_ff @(posedge i_vgaclk) begin
    if (i_rst) begin
      r_state    <= StClear;
      r_cnt      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_char     <= BLANK;
      r_writeack <= 1'b0;
      r_dropped  <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_char     <= w_char_nxt;
      r_writeack <= w_writeack_nxt;
      r_dropped  <= w_dropped_nxt;
      r_rd_ok    <= w_rd_ok;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_char_nxt     = r_char;
    w_writeack_nxt = r_writeack;
    w_dropped_nxt  = 1'b0;
    w_we           = 1'b0;
    w_waddr        = w_cell_addr;
    w_wdata        = r_char;

    unique case (r_state)
      StClear: begin
        // writereq stays pending here; the sender keeps holding it.
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = BLANK;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StIdle: begin
        if (i_writereq) begin
          w_x_nxt     = i_xwrite;
          w_y_nxt     = i_ywrite;
          w_char_nxt  = i_charin;
          w_state_nxt = StWrite;
        end
      end
      StWrite: begin
        w_we          = w_wr_ok;
        w_dropped_nxt = ~w_wr_ok;
        // Never raise the ack while the request is low.
        w_writeack_nxt = i_writereq;
        w_state_nxt    = StAck;
      end
      StAck: begin
        if (!i_writereq) begin
          w_writeack_nxt = 1'b0;
          w_state_nxt    = StIdle;
        end
      end
      default: begin
        w_state_nxt = StClear;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Out-of-range reads are steered to address 0 and masked to BLANK on the output.
  assign w_rd_ok = in_bounds(i_rdx, i_rdy, COLS, ROWS);
  assign w_raddr = w_rd_ok ? (ADDRW'(i_rdy) * ADDRW'(COLS) + ADDRW'(i_rdx)) : '0;

  termbuf_ram #(
    .DEPTH(DEPTH),
    .WIDTH(CW),
    .ADDRW(ADDRW)
  ) u_ram (
    .i_clk  (i_vgaclk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_q)
  );

  assign o_rdchar   = r_rd_ok ? w_ram_q : BLANK;
  assign o_writeack = r_writeack;
  assign o_dropped  = r_dropped;
  assign o_busy     = (r_state == StClear);

endmodule

// File: tb/tb_termbuf.sv
// Self-checking bench for termbuf: directed corner cases plus randomized writes/reads
// checked against a flat array model of the 100x30 screen.
module tb_termbuf;

  logic       clk = 1'b0;
  logic       rst;
  logic       writereq;
  logic [6:0] xwrite;
  logic [4:0] ywrite;
  logic [7:0] charin;
  logic       writeack;
  logic       busy;
  logic       dropped;
  logic [6:0] rdx;
  logic [4:0] rdy;
  logic [7:0] rdchar;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] model [3000];

  always #5 clk = ~clk;

  termbuf dut (
    .i_vgaclk  (clk),
    .i_rst     (rst),
    .i_writereq(writereq),
    .i_xwrite  (xwrite),
    .i_ywrite  (ywrite),
    .i_charin  (charin),
    .o_writeack(writeack),
    .o_busy    (busy),
    .o_dropped (dropped),
    .i_rdx     (rdx),
    .i_rdy     (rdy),
    .o_rdchar  (rdchar)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int x, input int y);
    if (x < 100 && y < 30) return model[y * 100 + x];
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3000; i++) model[i] = 8'h00;
  endtask

  // Called at a negedge; returns at the negedge where busy is first seen low.
  task automatic wait_sweep(input string tag);
    int   cyc;
    logic ack_seen;
    cyc = 0;
    ack_seen = 1'b0;
    while (busy && cyc < 4000) begin
      if (writeack) ack_seen = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, cyc, 3000);
    check_eq({tag, "_ack_during_clear"}, ack_seen, 1'b0);
  endtask

  // Finish a request that was already held high during the sweep.
  task automatic finish_held(input string tag, input int x, input int y, input logic [7:0] c);
    int n;
    n = 0;
    while (!writeack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_held_ack_latency"}, n, 2);
    if (x < 100 && y < 30) model[y * 100 + x] = c;
    writereq = 1'b0;
    @(negedge clk);
    check_eq({tag, "_held_ack_fall"}, writeack, 1'b0);
  endtask

  task automatic do_write(input int x, input int y, input logic [7:0] c);
    int   n;
    logic exp_drop;
    exp_drop = !(x < 100 && y < 30);
    xwrite   = 7'(x);
    ywrite   = 5'(y);
    charin   = c;
    writereq = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!writeack && n < 20);
    check_eq("ack_latency", n, 2);
    check_eq("dropped_pulse", dropped, exp_drop);
    if (!exp_drop) model[y * 100 + x] = c;
    writereq = 1'b0;
    @(negedge clk);
    check_eq("ack_fall", writeack, 1'b0);
    check_eq("dropped_once", dropped, 1'b0);
  endtask

  task automatic read_check(input string tag, input int x, input int y);
    rdx = 7'(x);
    rdy = 5'(y);
    @(negedge clk);
    check_eq(tag, rdchar, model_rd(x, y));
  endtask

  task automatic read_sweep(input string tag);
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 100; x++) begin
        read_check(tag, x, y);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    writereq = 1'b0;
    xwrite   = '0;
    ywrite   = '0;
    charin   = '0;
    rdx      = '0;
    rdy      = '0;
    model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_writeack", writeack, 1'b0);
    check_eq("rst_dropped", dropped, 1'b0);
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_rdchar", rdchar, 8'h00);

    // Sweep with a request held high throughout
    xwrite   = 7'd3;
    ywrite   = 5'd4;
    charin   = 8'h77;
    writereq = 1'b1;
    rst      = 1'b0;
    wait_sweep("sweep1");
    finish_held("sweep1", 3, 4, 8'h77);
    read_sweep("after_clear");

    // Basic write and read-back
    do_write(5, 2, 8'h2A);
    read_check("read_5_2", 5, 2);

    // Corners and their neighbours
    do_write(99, 29, 8'h41);
    do_write(0, 0, 8'h42);
    read_check("corner_99_29", 99, 29);
    read_check("corner_0_0", 0, 0);
    read_check("nbr_98_29", 98, 29);
    read_check("nbr_1_0", 1, 0);

    // Out-of-range writes are acked and dropped
    do_write(100, 3, 8'h99);
    do_write(10, 30, 8'h98);
    read_check("oor_read_100_3", 100, 3);
    read_check("alias_0_4", 0, 4);
    read_check("oor_read_10_30", 10, 30);
    read_check("oor_read_127_31", 127, 31);

    // Read-first on a same-edge collision
    do_write(7, 7, 8'h11);
    xwrite   = 7'd7;
    ywrite   = 5'd7;
    charin   = 8'h55;
    writereq = 1'b1;
    @(negedge clk);
    rdx = 7'd7;
    rdy = 5'd7;
    @(negedge clk);
    check_eq("collide_old", rdchar, 8'h11);
    check_eq("collide_ack", writeack, 1'b1);
    model[7 * 100 + 7] = 8'h55;
    writereq = 1'b0;
    @(negedge clk);
    check_eq("collide_new", rdchar, 8'h55);
    check_eq("collide_ack_fall", writeack, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        read_check("rand_read", $urandom_range(0, 110), $urandom_range(0, 31));
      end else begin
        do_write($urandom_range(0, 103), $urandom_range(0, 31), 8'($urandom));
      end
    end
    read_sweep("after_random");

    // Reset while in ACK with the request still held
    xwrite   = 7'd20;
    ywrite   = 5'd10;
    charin   = 8'hC3;
    writereq = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_ack", writeack, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ack", writeack, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b1);
    model_clear();
    xwrite = 7'd21;
    charin = 8'h3C;
    rst    = 1'b0;
    wait_sweep("sweep2");
    finish_held("sweep2", 21, 10, 8'h3C);
    read_check("sweep2_cell_21_10", 21, 10);
    read_check("sweep2_cell_20_10", 20, 10);
    read_check("sweep2_cell_5_2", 5, 2);
    read_check("sweep2_cell_99_29", 99, 29);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
